// File: rtl/branch_history_table.sv
// branch_history_table: 8-entry fully associative fetch-stage branch predictor.
// Combinational lookup of the fetch PC and one EX-stage training update per cycle.
// Each entry holds a tag of PC[31:2], a target and a 2-bit saturating counter.
// Optional macro BHT_BYPASS_EN forwards a same-cycle update to a matching lookup.
module branch_history_table #(
    parameter int ENTRIES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] PC_Cur,
    output logic [31:0] PredPC,
    output logic [1:0]  BranchFlags,
    output logic [2:0]  BranchIndex,
    input  logic        UpdEn,
    input  logic [31:0] UpdPC,
    input  logic [31:0] UpdTarget,
    input  logic        UpdTaken
);

    logic        validQ  [ENTRIES];
    logic        validD  [ENTRIES];
    logic [29:0] tagQ    [ENTRIES];
    logic [29:0] tagD    [ENTRIES];
    logic [31:0] targetQ [ENTRIES];
    logic [31:0] targetD [ENTRIES];
    logic [1:0]  ctrQ    [ENTRIES];
    logic [1:0]  ctrD    [ENTRIES];
    logic [2:0]  rpQ;
    logic [2:0]  rpD;

    logic        updHit;
    logic [2:0]  updIdx;
    logic        fwdSel;
    logic        lkHit;
    logic [2:0]  lkIdx;
    logic [1:0]  lkCtr;
    logic [31:0] lkTarget;
    logic        predTaken;

    // The low two PC bits never take part in matching.
    logic unusedPcBits;
    assign unusedPcBits = ^{PC_Cur[1:0], UpdPC[1:0]};

`ifdef BHT_BYPASS_EN
    // Lookup reads the post-update table when the update targets the fetch PC.
    assign fwdSel = UpdEn && (UpdPC[31:2] == PC_Cur[31:2]);
`else
    assign fwdSel = 1'b0;
`endif

    // Associative match of the update PC against the registered table.
    always_comb begin
        updHit = 1'b0;
        updIdx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (validQ[i] && (tagQ[i] == UpdPC[31:2])) begin
                updHit = 1'b1;
                updIdx = 3'(i);
            end
        end
    end

    // Next table contents: train a matching entry or allocate at the replacement pointer.
    always_comb begin
        validD  = validQ;
        tagD    = tagQ;
        targetD = targetQ;
        ctrD    = ctrQ;
        rpD     = rpQ;
        if (UpdEn) begin
            if (updHit) begin
                if (UpdTaken) begin
                    ctrD[updIdx]    = (ctrQ[updIdx] == 2'b11) ? 2'b11 : ctrQ[updIdx] + 2'b01;
                    targetD[updIdx] = UpdTarget;
                end else begin
                    ctrD[updIdx] = (ctrQ[updIdx] == 2'b00) ? 2'b00 : ctrQ[updIdx] - 2'b01;
                end
            end else if (UpdTaken) begin
                validD[rpQ]  = 1'b1;
                tagD[rpQ]    = UpdPC[31:2];
                targetD[rpQ] = UpdTarget;
                ctrD[rpQ]    = 2'b10;
                rpD          = rpQ + 3'd1;
            end
        end
    end

    // Associative lookup of the fetch PC, from registered or forwarded contents.
    always_comb begin
        lkHit    = 1'b0;
        lkIdx    = '0;
        lkCtr    = 2'b00;
        lkTarget = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if ((fwdSel ? validD[i] : validQ[i]) &&
                ((fwdSel ? tagD[i] : tagQ[i]) == PC_Cur[31:2])) begin
                lkHit    = 1'b1;
                lkIdx    = 3'(i);
                lkCtr    = fwdSel ? ctrD[i] : ctrQ[i];
                lkTarget = fwdSel ? targetD[i] : targetQ[i];
            end
        end
    end

    assign predTaken   = lkHit & lkCtr[1];
    assign PredPC      = predTaken ? lkTarget : PC_Cur + 32'd4;
    assign BranchFlags = {lkHit, predTaken};
    assign BranchIndex = lkIdx;

    // Table state register; reset empties the table and overrides any update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                validQ[i]  <= 1'b0;
                tagQ[i]    <= '0;
                targetQ[i] <= '0;
                ctrQ[i]    <= 2'b01;
            end
            rpQ <= '0;
        end else begin
            validQ  <= validD;
            tagQ    <= tagD;
            targetQ <= targetD;
            ctrQ    <= ctrD;
            rpQ     <= rpD;
        end
    end

endmodule

// File: tb/tb_branch_history_table.sv
// Directed testbench for branch_history_table with hand-computed expectations.
module tb_branch_history_table;

    logic        clk;
    logic        rst_n;
    logic [31:0] PC_Cur;
    logic [31:0] PredPC;
    logic [1:0]  BranchFlags;
    logic [2:0]  BranchIndex;
    logic        UpdEn;
    logic [31:0] UpdPC;
    logic [31:0] UpdTarget;
    logic        UpdTaken;

    int total = 0;
    int bad   = 0;

    branch_history_table dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .PC_Cur      (PC_Cur),
        .PredPC      (PredPC),
        .BranchFlags (BranchFlags),
        .BranchIndex (BranchIndex),
        .UpdEn       (UpdEn),
        .UpdPC       (UpdPC),
        .UpdTarget   (UpdTarget),
        .UpdTaken    (UpdTaken)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    // Present a PC and check flags, index and predicted PC.
    task automatic checkLookup(input string tag, input logic [31:0] pc, input logic [1:0] flags,
                               input logic [2:0] idx, input logic [31:0] pred);
        PC_Cur = pc;
        #1;
        checkOutput({tag, ".flags"}, {30'd0, BranchFlags}, {30'd0, flags});
        checkOutput({tag, ".idx"},   {29'd0, BranchIndex}, {29'd0, idx});
        checkOutput({tag, ".pred"},  PredPC, pred);
    endtask

    // One-cycle update pulse, launched at the falling edge.
    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
        @(negedge clk);
        UpdEn     = 1'b1;
        UpdPC     = pc;
        UpdTarget = tgt;
        UpdTaken  = taken;
        @(posedge clk);
        #1;
        UpdEn = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        PC_Cur    = 32'h100;
        UpdEn     = 1'b0;
        UpdPC     = '0;
        UpdTarget = '0;
        UpdTaken  = 1'b0;

        // Reset state.
        #3;
        checkLookup("reset", 32'h100, 2'b00, 3'd0, 32'h104);
        checkLookup("wrap", 32'hFFFF_FFFC, 2'b00, 3'd0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Allocate and train 0x100.
        applyStimulus(32'h100, 32'h200, 1'b1);
        checkLookup("alloc", 32'h100, 2'b11, 3'd0, 32'h200);
        checkLookup("other", 32'h104, 2'b00, 3'd0, 32'h108);
        applyStimulus(32'h100, 32'h200, 1'b1);
        applyStimulus(32'h100, 32'h240, 1'b1);
        checkLookup("satT", 32'h100, 2'b11, 3'd0, 32'h240);

        // Counter walk down: 11 -> 10 -> 01 -> 00 -> 00.
        applyStimulus(32'h100, 32'h999, 1'b0);
        checkLookup("nt1", 32'h100, 2'b11, 3'd0, 32'h240);
        applyStimulus(32'h100, 32'h999, 1'b0);
        checkLookup("nt2", 32'h100, 2'b10, 3'd0, 32'h104);
        applyStimulus(32'h100, 32'h999, 1'b0);
        applyStimulus(32'h100, 32'h999, 1'b0);
        checkLookup("nt4", 32'h100, 2'b10, 3'd0, 32'h104);
        // From 00 one taken gives 01 (still not taken), a second gives 10.
        applyStimulus(32'h100, 32'h280, 1'b1);
        checkLookup("up1", 32'h100, 2'b10, 3'd0, 32'h104);
        applyStimulus(32'h100, 32'h2C0, 1'b1);
        checkLookup("up2", 32'h100, 2'b11, 3'd0, 32'h2C0);

        // Replacement: nine PCs fill 0..7 then overwrite entry 0.
        doReset();
        checkLookup("clr", 32'h100, 2'b00, 3'd0, 32'h104);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(32'(i * 4), 32'h1000 + 32'(i * 4), 1'b1);
        end
        checkLookup("evict", 32'h000, 2'b00, 3'd0, 32'h004);
        checkLookup("new0", 32'h020, 2'b11, 3'd0, 32'h1020);
        checkLookup("e1", 32'h004, 2'b11, 3'd1, 32'h1004);
        checkLookup("e7", 32'h01C, 2'b11, 3'd7, 32'h101C);
        applyStimulus(32'h500, 32'h5000, 1'b0);
        checkLookup("ntmiss", 32'h500, 2'b00, 3'd0, 32'h504);
        applyStimulus(32'h600, 32'h6000, 1'b1);
        checkLookup("rp1", 32'h600, 2'b11, 3'd1, 32'h6000);
        checkLookup("gone1", 32'h004, 2'b00, 3'd0, 32'h008);

        // Same-cycle lookup and update on an empty table.
        doReset();
        @(negedge clk);
        PC_Cur    = 32'h300;
        UpdEn     = 1'b1;
        UpdPC     = 32'h300;
        UpdTarget = 32'h400;
        UpdTaken  = 1'b1;
        #1;
`ifdef BHT_BYPASS_EN
        checkOutput("same.flags", {30'd0, BranchFlags}, 32'd3);
        checkOutput("same.pred", PredPC, 32'h400);
`else
        checkOutput("same.flags", {30'd0, BranchFlags}, 32'd0);
        checkOutput("same.pred", PredPC, 32'h304);
`endif
        checkOutput("same.idx", {29'd0, BranchIndex}, 32'd0);
        @(posedge clk);
        #1;
        UpdEn = 1'b0;
        checkLookup("after", 32'h300, 2'b11, 3'd0, 32'h400);

        // Asynchronous reset between edges with an update pending.
        @(negedge clk);
        UpdEn     = 1'b1;
        UpdPC     = 32'h700;
        UpdTarget = 32'h7000;
        UpdTaken  = 1'b1;
        checkLookup("pre", 32'h300, 2'b11, 3'd0, 32'h400);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("arst.flags", {30'd0, BranchFlags}, 32'd0);
        checkOutput("arst.pred", PredPC, 32'h304);
        @(posedge clk);
        #1;
        UpdEn = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkLookup("noalloc", 32'h700, 2'b00, 3'd0, 32'h704);
        checkLookup("cleared", 32'h300, 2'b00, 3'd0, 32'h304);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
